// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register and operand-forwarding stage for the 16-bit ALU.
// Define IDEX_FORWARD_EN to forward EX/MEM and MEM/WB results; otherwise operands come from the register only.
module id_ex_operand_stage #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned OP_WIDTH   = 4,
    parameter int unsigned IDX_WIDTH  = 4,
    parameter logic [OP_WIDTH-1:0]  NOP_OP = '1,
    parameter logic [IDX_WIDTH-1:0] NO_REG = '1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [OP_WIDTH-1:0]   id_alu_op,
    input  logic [IDX_WIDTH-1:0]  id_rs_idx,
    input  logic [IDX_WIDTH-1:0]  id_rt_idx,
    input  logic [DATA_WIDTH-1:0] id_rs_val,
    input  logic [DATA_WIDTH-1:0] id_rt_val,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic                  id_b_imm,
    input  logic [IDX_WIDTH-1:0]  id_dst_idx,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic [IDX_WIDTH-1:0]  exm_dst_idx,
    input  logic                  exm_reg_write,
    input  logic [DATA_WIDTH-1:0] exm_result,
    input  logic [IDX_WIDTH-1:0]  mwb_dst_idx,
    input  logic                  mwb_reg_write,
    input  logic [DATA_WIDTH-1:0] mwb_result,
    output logic                  ex_valid,
    output logic [OP_WIDTH-1:0]   alu_op,
    output logic [DATA_WIDTH-1:0] srcdata_a,
    output logic [DATA_WIDTH-1:0] srcdata_b,
    output logic [DATA_WIDTH-1:0] ex_store_data,
    output logic [IDX_WIDTH-1:0]  ex_dst_idx,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic [15:0]           bubble_cnt
);

    logic                  valid_q;
    logic [OP_WIDTH-1:0]   op_q;
    logic [IDX_WIDTH-1:0]  rs_idx_q;
    logic [IDX_WIDTH-1:0]  rt_idx_q;
    logic [DATA_WIDTH-1:0] rs_val_q;
    logic [DATA_WIDTH-1:0] rt_val_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic                  b_imm_q;
    logic [IDX_WIDTH-1:0]  dst_q;
    logic                  reg_write_q;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic [15:0]           bubble_cnt_q;
    logic [DATA_WIDTH-1:0] rs_fwd;
    logic [DATA_WIDTH-1:0] rt_fwd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q      <= 1'b0;
            op_q         <= NOP_OP;
            rs_idx_q     <= NO_REG;
            rt_idx_q     <= NO_REG;
            rs_val_q     <= '0;
            rt_val_q     <= '0;
            imm_q        <= '0;
            b_imm_q      <= 1'b0;
            dst_q        <= NO_REG;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            bubble_cnt_q <= '0;
        end else if (flush || (!stall && !id_valid)) begin
            // flush overrides stall; an empty ID slot also becomes a bubble
            valid_q      <= 1'b0;
            op_q         <= NOP_OP;
            rs_idx_q     <= NO_REG;
            rt_idx_q     <= NO_REG;
            rs_val_q     <= '0;
            rt_val_q     <= '0;
            imm_q        <= '0;
            b_imm_q      <= 1'b0;
            dst_q        <= NO_REG;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            if (bubble_cnt_q != '1) bubble_cnt_q <= bubble_cnt_q + 16'd1;
        end else if (!stall) begin
            valid_q      <= 1'b1;
            op_q         <= id_alu_op;
            rs_idx_q     <= id_rs_idx;
            rt_idx_q     <= id_rt_idx;
            rs_val_q     <= id_rs_val;
            rt_val_q     <= id_rt_val;
            imm_q        <= id_imm;
            b_imm_q      <= id_b_imm;
            dst_q        <= id_dst_idx;
            reg_write_q  <= id_reg_write;
            mem_read_q   <= id_mem_read;
            mem_write_q  <= id_mem_write;
        end
    end

`ifdef IDEX_FORWARD_EN
    // EX/MEM is the younger producer, so it wins over MEM/WB
    always_comb begin
        rs_fwd = rs_val_q;
        rt_fwd = rt_val_q;
        if (exm_reg_write && exm_dst_idx == rs_idx_q && rs_idx_q != NO_REG)
            rs_fwd = exm_result;
        else if (mwb_reg_write && mwb_dst_idx == rs_idx_q && rs_idx_q != NO_REG)
            rs_fwd = mwb_result;
        if (exm_reg_write && exm_dst_idx == rt_idx_q && rt_idx_q != NO_REG)
            rt_fwd = exm_result;
        else if (mwb_reg_write && mwb_dst_idx == rt_idx_q && rt_idx_q != NO_REG)
            rt_fwd = mwb_result;
    end
`else
    logic unused_fwd;
    assign rs_fwd     = rs_val_q;
    assign rt_fwd     = rt_val_q;
    assign unused_fwd = ^{exm_dst_idx, exm_reg_write, exm_result,
                          mwb_dst_idx, mwb_reg_write, mwb_result, rs_idx_q, rt_idx_q};
`endif

    assign ex_valid      = valid_q;
    assign alu_op        = op_q;
    assign srcdata_a     = rs_fwd;
    assign srcdata_b     = b_imm_q ? imm_q : rt_fwd;
    assign ex_store_data = rt_fwd;
    assign ex_dst_idx    = dst_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign bubble_cnt    = bubble_cnt_q;

endmodule
